// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key-code types, keypad map and seven-segment font.
package keypad_pkg;

    typedef logic [3:0] hex_t;

    // Indexed by {row, col}; entry 0 is row 0 col 0.
    localparam hex_t [15:0] KEYMAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Active-low {g,f,e,d,c,b,a}; entry 0 is glyph 0.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        return {v[3] | v[2], v[3] | v[1]};
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: hex code to active-low segment pattern.
module seven_seg_decoder
    import keypad_pkg::*;
(
    input  hex_t       hex,
    output logic [6:0] seg
);

    assign seg = SEG_FONT[hex];

endmodule

// File: rtl/keypad_digit_display.sv
// keypad_digit_display: captures keypad events into a two-key history and
// multiplexes both digits onto a dual seven-segment display.
module keypad_digit_display
    import keypad_pkg::*;
#(
    parameter int REFRESH_DIV  = 48_000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rc,
    input  logic       en,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic [1:0] key_count,
    output logic       err,
    output logic [1:0] an,
    output logic [6:0] seg
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    hex_t          new_q, new_d, old_q, old_d;
    logic [1:0]    kc_q, kc_d;
    logic          err_q, err_d;
    logic [1:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          valid, cap, wrap, blank;
    hex_t          code, shown;
    logic [6:0]    font_seg;

    seven_seg_decoder u_dec (
        .hex (shown),
        .seg (font_seg)
    );

    always_comb begin
        valid = $onehot(rc[7:4]) && $onehot(rc[3:0]);
        code  = KEYMAP[{onehot_idx(rc[7:4]), onehot_idx(rc[3:0])}];
        cap   = en && valid;
        new_d = cap ? code : new_q;
        old_d = cap ? new_q : old_q;
        kc_d  = (cap && kc_q != 2'd2) ? kc_q + 2'd1 : kc_q;
        err_d = en && !valid;
        wrap  = 32'(cnt_q) == REFRESH_DIV - 1;
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        sel_d = sel_q ^ wrap;
        // Left digit is only meaningful once two keys are held.
        blank = 32'(cnt_q) < BLANK_CYCLES || kc_q == 2'd0 || (sel_q && kc_q == 2'd1);
        shown = sel_q ? old_q : new_q;
        an_d  = blank ? 2'b11 : (sel_q ? 2'b01 : 2'b10);
        seg_d = blank ? SEG_BLANK : font_seg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
            new_q <= '0;
            old_q <= '0;
            kc_q  <= '0;
            err_q <= 1'b0;
            an_q  <= 2'b11;
            seg_q <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            new_q <= new_d;
            old_q <= old_d;
            kc_q  <= kc_d;
            err_q <= err_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign digit_new = new_q;
    assign digit_old = old_q;
    assign key_count = kc_q;
    assign err       = err_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: doc/keypad_digit_display.md
Name: keypad_digit_display

Overview:
Consumes the (rc, en) key-event stream produced by keypadFSM. It decodes each accepted key into a 4-bit hex code and keeps a two-deep history (newest and previous key). It time-multiplexes both digits onto the shared dual seven-segment display. It is the stage directly downstream of the keypad scanner, and its outputs drive the board display pins.

Parameters:
REFRESH_DIV, 48_000, clk cycles per displayed digit slot (1 ms at 48 MHz); legal range 4..2^20.
BLANK_CYCLES, 480, cycles at the start of each slot with both anodes off (anti-ghosting); legal range 0..REFRESH_DIV-1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rc  input  8  key event from keypadFSM: rc[7:4] row one-hot, rc[3:0] column one-hot
en  input  1  one-cycle key-accepted strobe from keypadFSM; rc is valid when en=1
digit_new  output  4  hex code of the most recent key
digit_old  output  4  hex code of the key before it
key_count  output  2  number of keys captured, saturating at 2
err  output  1  one-cycle pulse: en seen with rc not one-hot in row or column
an  output  2  digit anodes, active-low; an[0] = right (new) digit, an[1] = left (old) digit
seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Clocking: single clock domain. All state updates on the posedge of clk. reset is synchronous and active-high.
- Reset values: digit_new=0, digit_old=0, key_count=0, err=0, an=2'b11, seg=7'h7F, refresh counter=0, sel=0.
- Reset mid-operation: all registers return to their reset values on the first edge with reset=1. en is ignored while reset=1.
- Key decode: r = index of the set bit in rc[7:4]; c = index of the set bit in rc[3:0].
  - Row 0: 1, 2, 3, A
  - Row 1: 4, 5, 6, B
  - Row 2: 7, 8, 9, C
  - Row 3: E, 0, F, D
- Capture (en=1 and both nibbles one-hot): on that edge, digit_old<=digit_new, digit_new<=code, key_count<=min(key_count+1, 2). Latency: outputs change one cycle after the en cycle.
- Invalid event (en=1 and either nibble not one-hot, including zero): no history change. err=1 for exactly the next cycle.
- en=0: rc is don't-care and no state changes. Back-to-back en pulses on consecutive cycles are each captured.
- Refresh counter: counts 0..REFRESH_DIV-1, then wraps to 0. On wrap, sel toggles.
  - sel=0 shows digit_new on an[0].
  - sel=1 shows digit_old on an[1].
- Blanking rules:
  - While counter < BLANK_CYCLES, next an=2'b11.
  - Blank digits: if key_count=0, both digits are blank. If key_count=1, the left digit is blank.
  - A blanked slot drives an=2'b11 and seg=7'h7F.
- Output registration: an and seg are registered, so they reflect the counter, sel and digit state with a 1-cycle delay. A new key is therefore visible on seg no later than the next selected slot.
- Only one anode is ever low at a time. an=2'b00 is illegal and the bench asserts on it every cycle.
- Segment font: standard hex 0-F, lowercase b and d, active-low. Examples: 0 to 7'h40, 1 to 7'h79, 6 to 7'h02, A to 7'h08, E to 7'h06, F to 7'h0E.

Decomposition:
- Package keypad_pkg holds:
  - typedef hex_t (logic [3:0])
  - KEYMAP constant: 16-entry array indexed by {r,c}, giving hex_t
  - SEG_FONT constant: 16 entries of 7-bit active-low patterns
  - SEG_BLANK = 7'h7F
- Sub-module seven_seg_decoder: combinational, hex_t in, seg out, uses SEG_FONT. Instantiated once on the muxed digit.
- Counter, sel, history and one-hot checks stay in keypad_digit_display.

Test Plan:
Every test uses REFRESH_DIV=8, BLANK_CYCLES=2 and reset held for 5 cycles first.
1. Reset -> an=11, seg=7F, key_count=0 and both digits 0; no anode goes low for 32 cycles.
2. en pulse with rc=8'b0001_0001 -> next cycle digit_new=1, key_count=1. In sel=0 slots, after 2 blank cycles an=10 and seg=7'h79. sel=1 slots stay an=11.
3. Then en with rc=8'b0010_0100 -> digit_new=6, digit_old=1, key_count=2. Slots alternate: an=10 with seg=02, and an=01 with seg=79. Each slot lasts 6 active cycles after 2 blank cycles.
4. en with rc=8'b0011_0001, then en with rc=8'b0100_0000 -> err pulses once per event. Digits and key_count are unchanged.
5. Back-to-back en on consecutive cycles with rc for row3 col0 then row3 col2 -> digit_old=E, digit_new=F, key_count stays 2.
6. Assert reset mid-slot with an=01 -> next cycle all outputs are at reset values. A subsequent key press (row0 col3) gives digit_new=A and key_count=1.
